banner_scroller: RTL and testbench

- Downstream consumer of the banner bitmap ROM (57-bit rows, 129 rows, 1-cycle registered-address read).
- Per frame: walks a window of VIS_ROWS consecutive ROM rows starting at a scroll offset, reading each row from the ROM.
- Serializes each row MSB-first onto a valid/ready pixel stream for the display driver.
- Advances the offset by one row per frame when scrolling is enabled, so the banner rolls across the display.

---
 rtl/banner_scroller.sv | 151 +++++++++++++++
 tb/tb_banner_scroller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banner_scroller.sv
// Scrolls a VIS_ROWS window over the banner ROM and serializes each row MSB-first
// on a valid/ready pixel stream. Define BANNER_SCROLLER_BLANK_EN to blank rows past the ROM end instead of wrapping.
module banner_scroller #(
  parameter int ROW_W    = 57,
  parameter int NUM_ROWS = 129,
  parameter int ADDR_W   = 8,
  parameter int VIS_ROWS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              scroll_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROW_W-1:0]  rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_sol,
  output logic              pix_eof,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] offset
);
  localparam int CNT_W  = $clog2(ROW_W + 1);
  localparam int RIDX_W = $clog2(VIS_ROWS + 1);
  localparam logic [ADDR_W:0]   NUM_ROWS_S = (ADDR_W+1)'(NUM_ROWS);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(ROW_W - 1);
  localparam logic [RIDX_W-1:0] LAST_ROW   = RIDX_W'(VIS_ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [RIDX_W-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ROW_W-1:0]  shreg_q, shreg_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W:0]   row_sum;
`ifdef BANNER_SCROLLER_BLANK_EN
  logic              blank_q, blank_d;
`endif

  // Unwrapped address of the row after row_idx; one extra bit so the sum cannot overflow.
  function automatic logic [ADDR_W:0] next_row_sum(input logic [ADDR_W-1:0] off,
                                                   input logic [RIDX_W-1:0] idx);
    return {1'b0, off} + (ADDR_W+1)'(idx) + (ADDR_W+1)'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W:0] sum);
    logic [ADDR_W:0] w;
    w = (sum >= NUM_ROWS_S) ? sum - NUM_ROWS_S : sum;
    return w[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    offset_d     = offset_q;
    row_idx_d    = row_idx_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;
    row_sum      = next_row_sum(offset_q, row_idx_q);
`ifdef BANNER_SCROLLER_BLANK_EN
    blank_d      = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          row_idx_d  = '0;
          rom_addr_d = offset_q;
`ifdef BANNER_SCROLLER_BLANK_EN
          blank_d    = 1'b0;
`endif
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        state_d   = S_SHIFT;
        bit_cnt_d = '0;
`ifdef BANNER_SCROLLER_BLANK_EN
        shreg_d   = blank_q ? '0 : rom_data;
`else
        shreg_d   = rom_data;
`endif
      end
      S_SHIFT: begin
        if (pix_ready) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (row_idx_q == LAST_ROW) begin
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
              if (scroll_en) begin
                offset_d = (offset_q == LAST_ADDR) ? '0 : offset_q + 1'b1;
              end
            end else begin
              state_d    = S_FETCH;
              row_idx_d  = row_idx_q + 1'b1;
              rom_addr_d = wrap_addr(row_sum);
`ifdef BANNER_SCROLLER_BLANK_EN
              blank_d    = (row_sum >= NUM_ROWS_S);
`endif
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      offset_q     <= '0;
      row_idx_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      frame_done_q <= 1'b0;
`ifdef BANNER_SCROLLER_BLANK_EN
      blank_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      offset_q     <= offset_d;
      row_idx_q    <= row_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      frame_done_q <= frame_done_d;
`ifdef BANNER_SCROLLER_BLANK_EN
      blank_q      <= blank_d;
`endif
    end
  end

  // Stream outputs come from registers only, so pix_valid never sees pix_ready.
  assign pix_valid  = (state_q == S_SHIFT);
  assign pix_data   = pix_valid & shreg_q[ROW_W-1];
  assign pix_sol    = pix_valid && (bit_cnt_q == '0);
  assign pix_eof    = pix_valid && (bit_cnt_q == LAST_BIT) && (row_idx_q == LAST_ROW);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign rom_addr   = rom_addr_q;
  assign offset     = offset_q;
endmodule

// File: tb/tb_banner_scroller.sv
// Randomized bench for banner_scroller: a full-width instance plus a narrow-row
// instance (fast frames) for the long scrolling run; both read a bench ROM model.
`timescale 1ns/1ps
module tb_banner_scroller;
  localparam int NR = 129, VR = 32, MW = 57, SW = 4, LIMIT = 20000;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, scroll_en = 1'b0, pix_ready = 1'b0;
  bit   use_s = 1'b0;
  logic m_start, s_start;
  logic [7:0] m_addr, s_addr, m_off, s_off;
  logic [MW-1:0] m_data;
  logic [SW-1:0] s_data;
  logic m_v, m_d, m_sol, m_eof, m_busy, m_fd;
  logic s_v, s_d, s_sol, s_eof, s_busy, s_fd;
  logic v, d, sol, eof, bsy, fd;
  logic [7:0] addr, off;
  logic [MW-1:0] rom [NR];

  int checks = 0, errors = 0;
  bit cap_q[$], exp_q[$];
  int cap_a[$], exp_a[$];
  int lat, sol_bad, eof_cnt, eof_bad, stall_bad;
  bit busy1, fd_ok, tmo;
  int m_exp_off = 0;

  always #5 clk = ~clk;

  assign m_start = start & ~use_s;
  assign s_start = start & use_s;
  assign v    = use_s ? s_v    : m_v;
  assign d    = use_s ? s_d    : m_d;
  assign sol  = use_s ? s_sol  : m_sol;
  assign eof  = use_s ? s_eof  : m_eof;
  assign bsy  = use_s ? s_busy : m_busy;
  assign fd   = use_s ? s_fd   : m_fd;
  assign addr = use_s ? s_addr : m_addr;
  assign off  = use_s ? s_off  : m_off;

  always @(posedge clk) begin
    m_data <= rom[m_addr];
    s_data <= rom[s_addr][SW-1:0];
  end

  banner_scroller u_m (
    .clk(clk), .rst(rst), .start(m_start), .scroll_en(scroll_en),
    .rom_addr(m_addr), .rom_data(m_data), .pix_valid(m_v), .pix_ready(pix_ready),
    .pix_data(m_d), .pix_sol(m_sol), .pix_eof(m_eof), .busy(m_busy),
    .frame_done(m_fd), .offset(m_off));

  banner_scroller #(.ROW_W(SW)) u_s (
    .clk(clk), .rst(rst), .start(s_start), .scroll_en(scroll_en),
    .rom_addr(s_addr), .rom_data(s_data), .pix_valid(s_v), .pix_ready(pix_ready),
    .pix_data(s_d), .pix_sol(s_sol), .pix_eof(s_eof), .busy(s_busy),
    .frame_done(s_fd), .offset(s_off));

  // Reference frame: VR rows from offset o, each row MSB-first, wrapped or blanked past the ROM end.
  task automatic build_expect(input int o, input int rw);
    exp_q.delete();
    exp_a.delete();
    for (int r = 0; r < VR; r++) begin
      int a;
      bit blank;
      a = (o + r) % NR;
      blank = 1'b0;
`ifdef BANNER_SCROLLER_BLANK_EN
      blank = (o + r) >= NR;
`endif
      exp_a.push_back(a);
      for (int k = rw - 1; k >= 0; k--) exp_q.push_back(blank ? 1'b0 : rom[a][k]);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) return i;
    return (cap_q.size() == exp_q.size()) ? -1 : n;
  endfunction

  function automatic int first_adiff();
    int n;
    n = (cap_a.size() < exp_a.size()) ? cap_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) if (cap_a[i] != exp_a[i]) return i;
    return (cap_a.size() == exp_a.size()) ? -1 : n;
  endfunction

  // Issues start in the current cycle and records one frame; returns in the frame_done cycle.
  task automatic run_frame(input int rdy_pct, input bit inj);
    int rw, cyc;
    bit pv, pr, pd, ps, pe, done;
    rw = use_s ? SW : MW;
    cap_q.delete();
    cap_a.delete();
    lat = -1; sol_bad = 0; eof_cnt = 0; eof_bad = 0; stall_bad = 0;
    busy1 = 0; fd_ok = 0; tmo = 0; done = 0; cyc = 0;
    pv = 0; pr = 0; pd = 0; ps = 0; pe = 0;
    start = 1'b1;
    while (!done && cyc < LIMIT) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == 1) busy1 = bsy;
      if (v === 1'b1 && lat < 0) lat = cyc;
      if (pv && !pr && ({v, d, sol, eof} !== {pv, pd, ps, pe})) stall_bad++;
      if (v === 1'b1 && eof !== (cap_q.size() == VR * rw - 1)) eof_bad++;
      pix_ready = ($urandom_range(0, 99) < rdy_pct);
      if (inj && v === 1'b1 && $urandom_range(0, 15) == 0) start = 1'b1;
      if (v === 1'b1 && pix_ready) begin
        if (sol !== (cap_q.size() % rw == 0)) sol_bad++;
        if (sol === 1'b1) cap_a.push_back(int'(addr));
        cap_q.push_back(d);
        if (eof === 1'b1) begin
          eof_cnt++;
          done = 1;
        end
      end
      pv = v; pr = pix_ready; pd = d; ps = sol; pe = eof;
    end
    if (done) begin
      @(posedge clk); #1;
      start = 1'b0;
      pix_ready = 1'b0;
      fd_ok = (fd === 1'b1) && (bsy === 1'b0) && (v === 1'b0);
    end else begin
      tmo = 1;
    end
  endtask

  task automatic test_reset();
    use_s = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({v, d, sol, eof, bsy, fd} !== 6'b0 || addr !== 8'd0 || off !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v%b d%b sol%b eof%b busy%b fd%b addr%0d off%0d, want all 0",
               v, d, sol, eof, bsy, fd, addr, off);
    end
    checks++;
    if ({s_v, s_busy, s_fd} !== 3'b0 || s_addr !== 8'd0 || s_off !== 8'd0) begin
      errors++;
      $display("FAIL reset_narrow: got v%b busy%b addr%0d off%0d, want all 0", s_v, s_busy, s_addr, s_off);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bsy !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy%b valid%b, want 0 0", bsy, v);
    end
  endtask

  task automatic test_first_frame();
    int bad, dif;
    use_s = 0;
    scroll_en = 0;
    build_expect(m_exp_off, MW);
    run_frame(100, 0);
    checks++;
    if (tmo) begin errors++; $display("FAIL first_timeout: got no frame end, want one"); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL first_latency: got %0d, want 3", lat); end
    checks++;
    if (!busy1) begin errors++; $display("FAIL first_busy: got 0 after start edge, want 1"); end
    bad = -1;
    for (int k = 0; k < MW; k++)
      if (bad < 0 && (k >= cap_q.size() || cap_q[k] !== (k >= 54))) bad = k;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL row0_pattern: first bad bit %0d, want 54 zeros then 3 ones", bad); end
    dif = first_diff();
    checks++;
    if (dif >= 0) begin errors++; $display("FAIL first_stream: differs at pixel %0d (got %0d px, want %0d)", dif, cap_q.size(), exp_q.size()); end
    checks++;
    if (sol_bad != 0) begin errors++; $display("FAIL first_sol: got %0d misplaced sol, want 0", sol_bad); end
    checks++;
    if (eof_cnt != 1 || eof_bad != 0) begin errors++; $display("FAIL first_eof: got cnt %0d bad %0d, want 1 0", eof_cnt, eof_bad); end
    checks++;
    if (!fd_ok) begin errors++; $display("FAIL first_frame_done: got fd%b busy%b, want 1 0", fd, bsy); end
    dif = first_adiff();
    checks++;
    if (dif >= 0) begin errors++; $display("FAIL first_addr: differs at row %0d", dif); end
    checks++;
    if (off !== 8'(m_exp_off)) begin errors++; $display("FAIL first_offset: got %0d, want %0d", off, m_exp_off); end
  endtask

  task automatic test_backpressure();
    int dif;
    use_s = 0;
    scroll_en = 1;
    build_expect(m_exp_off, MW);
    run_frame(50, 1);
    m_exp_off = (m_exp_off + 1) % NR;
    dif = first_diff();
    checks++;
    if (tmo || dif >= 0) begin errors++; $display("FAIL bp_stream: tmo %0d diff at %0d", tmo, dif); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles, want 0", stall_bad); end
    checks++;
    if (eof_cnt != 1 || eof_bad != 0 || sol_bad != 0) begin
      errors++; $display("FAIL bp_markers: eof cnt %0d bad %0d sol bad %0d, want 1 0 0", eof_cnt, eof_bad, sol_bad);
    end
    checks++;
    if (!fd_ok) begin errors++; $display("FAIL bp_frame_done: got fd%b busy%b, want 1 0", fd, bsy); end
    checks++;
    if (off !== 8'(m_exp_off)) begin errors++; $display("FAIL bp_offset: got %0d, want %0d", off, m_exp_off); end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bsy !== 1'b0) begin errors++; $display("FAIL start_in_shift_ignored: got busy %b, want 0", bsy); end
  endtask

  task automatic test_back_to_back();
    int dif;
    use_s = 0;
    scroll_en = 0;
    build_expect(m_exp_off, MW);
    run_frame(100, 0);
    dif = first_diff();
    checks++;
    if (tmo || dif >= 0 || !fd_ok) begin errors++; $display("FAIL b2b_first: tmo %0d diff %0d fd_ok %0d", tmo, dif, fd_ok); end
    run_frame(70, 0);
    checks++;
    if (lat != 3 || !busy1) begin errors++; $display("FAIL b2b_restart: got latency %0d busy %0d, want 3 1", lat, busy1); end
    dif = first_diff();
    checks++;
    if (tmo || dif >= 0) begin errors++; $display("FAIL b2b_stream: tmo %0d diff at %0d", tmo, dif); end
    checks++;
    if (off !== 8'(m_exp_off)) begin errors++; $display("FAIL b2b_offset: got %0d, want %0d", off, m_exp_off); end
  endtask

  task automatic test_reset_mid_row();
    int n, cyc, dif;
    use_s = 0;
    scroll_en = 0;
    build_expect(m_exp_off, MW);
    pix_ready = 1'b1;
    start = 1'b1;
    n = 0;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(v === 1'b1 && n == 5 * MW + 20) && cyc < LIMIT) begin
      if (v === 1'b1) n++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= LIMIT || d !== exp_q[5 * MW + 20] || sol !== 1'b0) begin
      errors++; $display("FAIL pre_reset_pixel: got d%b sol%b at %0d, want d%b sol0", d, sol, n, exp_q[5 * MW + 20]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({v, d, sol, eof, bsy, fd} !== 6'b0 || addr !== 8'd0 || off !== 8'd0) begin
      errors++;
      $display("FAIL midrow_reset: got v%b d%b sol%b eof%b busy%b fd%b addr%0d off%0d, want all 0",
               v, d, sol, eof, bsy, fd, addr, off);
    end
    pix_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_exp_off = 0;
    repeat (2) @(posedge clk);
    #1;
    build_expect(m_exp_off, MW);
    run_frame(100, 0);
    dif = first_diff();
    checks++;
    if (tmo || dif >= 0 || lat != 3) begin errors++; $display("FAIL post_reset_frame: tmo %0d diff %0d latency %0d", tmo, dif, lat); end
    checks++;
    if (off !== 8'd0) begin errors++; $display("FAIL post_reset_offset: got %0d, want 0", off); end
  endtask

  task automatic test_scroll_wrap();
    int exp_off, dif, adif, ones;
    use_s = 1;
    scroll_en = 1;
    exp_off = 0;
    for (int f = 0; f < NR; f++) begin
      checks++;
      if (off !== 8'(exp_off)) begin errors++; $display("FAIL scroll_offset: frame %0d got %0d, want %0d", f, off, exp_off); end
      build_expect(exp_off, SW);
      run_frame(100, 0);
      dif = first_diff();
      adif = first_adiff();
      checks++;
      if (tmo || dif >= 0 || adif >= 0 || eof_cnt != 1 || eof_bad != 0 || !fd_ok) begin
        errors++;
        $display("FAIL scroll_frame: frame %0d off %0d tmo %0d diff %0d adiff %0d eof %0d/%0d fd %0d",
                 f, exp_off, tmo, dif, adif, eof_cnt, eof_bad, fd_ok);
      end
      if (exp_off == 100) begin
        checks++;
        if (cap_a.size() != VR || cap_a[0] != 100 || cap_a[28] != 128 || cap_a[29] != 0 || cap_a[31] != 2) begin
          errors++; $display("FAIL wrap_addr_seq: got %0d rows, want 100..128,0,1,2", cap_a.size());
        end
`ifdef BANNER_SCROLLER_BLANK_EN
        ones = 0;
        for (int i = 29 * SW; i < cap_q.size(); i++) ones += int'(cap_q[i]);
        checks++;
        if (ones != 0) begin errors++; $display("FAIL blank_rows: got %0d set pixels in rows 29..31, want 0", ones); end
`endif
      end
      exp_off = (exp_off + 1) % NR;
    end
    checks++;
    if (off !== 8'd0) begin errors++; $display("FAIL scroll_wrap_end: got %0d, want 0", off); end
    ones = 0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rom[i] = MW'({$urandom(), $urandom()});
    rom[0] = 57'd7;
    test_reset();
    test_first_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_row();
    test_scroll_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
